// File: rtl/decode_modrm_fetch_pkg.sv
// Shared definitions for the ModR/M / SIB / displacement collector.
package decode_modrm_fetch_pkg;

   // Parse FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MODRM,
      ST_SIB,
      ST_DISP,
      ST_DONE
   } state_t;

   // Displacement length classes (0, 8 or 32 bits)
   typedef enum logic [1:0] {
      DISP_LEN_0,
      DISP_LEN_8,
      DISP_LEN_32
   } disp_len_t;

   // mod field encodings
   localparam logic [1:0] MOD_NODISP = 2'b00;
   localparam logic [1:0] MOD_DISP8  = 2'b01;
   localparam logic [1:0] MOD_DISP32 = 2'b10;
   localparam logic [1:0] MOD_REG    = 2'b11;

   // Register indices with special addressing meaning
   localparam logic [2:0] REG_ESP = 3'b100;
   localparam logic [2:0] REG_EBP = 3'b101;

   // Number of displacement bytes for a length class
   function automatic logic [2:0] disp_bytes(input disp_len_t len);
      logic [2:0] n;
      case (len)
         DISP_LEN_8:  n = 3'd1;
         DISP_LEN_32: n = 3'd4;
         default:     n = 3'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/decode_modrm_fetch_sib.sv
// SIB byte field decoder: scale/index/base, displacement class and the
// undefined-EA flag for an index of ESP combined with a nonzero scale.
module decode_sib
   import decode_modrm_fetch_pkg::*;
(
   input  logic [7:0] sib,
   input  logic [1:0] mod,
   output logic [1:0] scale,
   output logic [2:0] index,
   output logic       index_used,
   output logic [2:0] base,
   output logic       base_used,
   output logic [1:0] disp_len,
   output logic       ea_undefined
);

   // Field split plus displacement class selection
   always_comb begin
      scale        = sib[7:6];
      index        = sib[5:3];
      base         = sib[2:0];
      index_used   = (sib[5:3] != REG_ESP);
      ea_undefined = (sib[5:3] == REG_ESP) && (sib[7:6] != 2'b00);
      base_used    = 1'b1;
      disp_len     = DISP_LEN_0;
      if (mod == MOD_DISP8) begin
         disp_len = DISP_LEN_8;
      end else if (mod == MOD_DISP32) begin
         disp_len = DISP_LEN_32;
      end else if ((mod == MOD_NODISP) && (sib[2:0] == REG_EBP)) begin
         // no base register, absolute disp32 instead
         disp_len  = DISP_LEN_32;
         base_used = 1'b0;
      end
   end

endmodule

// File: rtl/decode_modrm_fetch.sv
// Byte-serial ModR/M + SIB + displacement collector producing one
// registered 32-bit address descriptor per instruction.
module decode_modrm_fetch
   import decode_modrm_fetch_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_mod,
   output logic [2:0]  out_reg,
   output logic [2:0]  out_rm,
   output logic        out_is_register,
   output logic        out_sib_present,
   output logic [1:0]  out_scale,
   output logic        out_index_used,
   output logic [2:0]  out_index,
   output logic        out_base_used,
   output logic [2:0]  out_base,
   output logic [31:0] out_disp,
   output logic        out_default_ss,
   output logic        out_ea_undefined,
   output logic [2:0]  out_length
);

   state_t      state_q, state_d;
   logic [7:0]  modrm_q, modrm_d;
   logic [7:0]  sib_q, sib_d;
   logic        sib_present_q, sib_present_d;
   logic [31:0] disp_q, disp_d;
   logic [2:0]  disp_rem_q, disp_rem_d;   // displacement bytes still to fetch
   logic [2:0]  disp_cnt_q, disp_cnt_d;   // total displacement bytes
   logic [1:0]  disp_idx_q, disp_idx_d;   // byte lane of next displacement byte

   logic        accept;
   logic [7:0]  sib_in;
   logic [1:0]  sib_scale, sib_len;
   logic [2:0]  sib_index, sib_base, sib_nbytes;
   logic        sib_index_used, sib_base_used, sib_undef;

   // The decoder sees the incoming byte while in SIB so the displacement
   // count is known on accept; afterwards it sees the latched byte.
   assign sib_in = (state_q == ST_SIB) ? byte_data : sib_q;

   decode_sib u_sib (
      .sib          (sib_in),
      .mod          (modrm_q[7:6]),
      .scale        (sib_scale),
      .index        (sib_index),
      .index_used   (sib_index_used),
      .base         (sib_base),
      .base_used    (sib_base_used),
      .disp_len     (sib_len),
      .ea_undefined (sib_undef)
   );

   assign sib_nbytes = disp_bytes(disp_len_t'(sib_len));
   assign byte_ready = ~flush & ((state_q == ST_MODRM) || (state_q == ST_SIB) ||
                                 (state_q == ST_DISP));
   assign accept     = byte_valid & byte_ready;
   assign busy       = (state_q != ST_IDLE);

   // Next-state and parse-register update; flush overrides everything
   always_comb begin
      state_d       = state_q;
      modrm_d       = modrm_q;
      sib_d         = sib_q;
      sib_present_d = sib_present_q;
      disp_d        = disp_q;
      disp_rem_d    = disp_rem_q;
      disp_cnt_d    = disp_cnt_q;
      disp_idx_d    = disp_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d       = ST_MODRM;
               modrm_d       = 8'h00;
               sib_d         = 8'h00;
               sib_present_d = 1'b0;
               disp_d        = 32'h0;
               disp_rem_d    = 3'd0;
               disp_cnt_d    = 3'd0;
               disp_idx_d    = 2'd0;
            end
         end
         ST_MODRM: begin
            if (accept) begin
               modrm_d = byte_data;
               if (byte_data[7:6] == MOD_REG) begin
                  state_d = ST_DONE;
               end else if (byte_data[2:0] == REG_ESP) begin
                  state_d = ST_SIB;
               end else if ((byte_data[7:6] == MOD_NODISP) && (byte_data[2:0] == REG_EBP)) begin
                  state_d    = ST_DISP;
                  disp_rem_d = 3'd4;
                  disp_cnt_d = 3'd4;
               end else if (byte_data[7:6] == MOD_DISP8) begin
                  state_d    = ST_DISP;
                  disp_rem_d = 3'd1;
                  disp_cnt_d = 3'd1;
               end else if (byte_data[7:6] == MOD_DISP32) begin
                  state_d    = ST_DISP;
                  disp_rem_d = 3'd4;
                  disp_cnt_d = 3'd4;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SIB: begin
            if (accept) begin
               sib_d         = byte_data;
               sib_present_d = 1'b1;
               disp_rem_d    = sib_nbytes;
               disp_cnt_d    = sib_nbytes;
               state_d       = (sib_nbytes == 3'd0) ? ST_DONE : ST_DISP;
            end
         end
         ST_DISP: begin
            if (accept) begin
               if (disp_cnt_q == 3'd1) begin
                  disp_d = {{24{byte_data[7]}}, byte_data};
               end else begin
                  disp_d[{disp_idx_q, 3'b000} +: 8] = byte_data;
               end
               disp_idx_d = disp_idx_q + 2'd1;
               disp_rem_d = disp_rem_q - 3'd1;
               if (disp_rem_q == 3'd1) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d       = ST_IDLE;
         sib_present_d = 1'b0;
         disp_d        = 32'h0;
         disp_rem_d    = 3'd0;
         disp_cnt_d    = 3'd0;
         disp_idx_d    = 2'd0;
      end
   end

   // State and parse registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         modrm_q       <= 8'h00;
         sib_q         <= 8'h00;
         sib_present_q <= 1'b0;
         disp_q        <= 32'h0;
         disp_rem_q    <= 3'd0;
         disp_cnt_q    <= 3'd0;
         disp_idx_q    <= 2'd0;
      end else begin
         state_q       <= state_d;
         modrm_q       <= modrm_d;
         sib_q         <= sib_d;
         sib_present_q <= sib_present_d;
         disp_q        <= disp_d;
         disp_rem_q    <= disp_rem_d;
         disp_cnt_q    <= disp_cnt_d;
         disp_idx_q    <= disp_idx_d;
      end
   end

   // Descriptor fields, driven only from registers and held at zero
   // whenever no descriptor is being presented
   always_comb begin
      out_valid        = (state_q == ST_DONE);
      out_mod          = 2'b00;
      out_reg          = 3'b000;
      out_rm           = 3'b000;
      out_is_register  = 1'b0;
      out_sib_present  = 1'b0;
      out_scale        = 2'b00;
      out_index_used   = 1'b0;
      out_index        = 3'b000;
      out_base_used    = 1'b0;
      out_base         = 3'b000;
      out_disp         = 32'h0;
      out_default_ss   = 1'b0;
      out_ea_undefined = 1'b0;
      out_length       = 3'd0;
      if (state_q == ST_DONE) begin
         out_mod         = modrm_q[7:6];
         out_reg         = modrm_q[5:3];
         out_rm          = modrm_q[2:0];
         out_is_register = (modrm_q[7:6] == MOD_REG);
         out_sib_present = sib_present_q;
         out_disp        = disp_q;
         out_length      = 3'd1 + {2'b00, sib_present_q} + disp_cnt_q;
         if (sib_present_q) begin
            out_scale        = sib_scale;
            out_index_used   = sib_index_used;
            out_index        = sib_index;
            out_base_used    = sib_base_used;
            out_base         = sib_base;
            out_ea_undefined = sib_undef;
         end else begin
            out_base      = modrm_q[2:0];
            out_base_used = ~((modrm_q[7:6] == MOD_NODISP) && (modrm_q[2:0] == REG_EBP));
         end
         out_default_ss = out_base_used && ((out_base == REG_ESP) || (out_base == REG_EBP));
      end
   end

endmodule

// File: tb/tb_decode_modrm_fetch.sv
// Scoreboard bench for decode_modrm_fetch: directed instruction byte
// sequences with hand-computed descriptors, plus timing/flush/hold checks.
module tb_decode_modrm_fetch;

   logic        clk = 1'b0;
   logic        reset, flush, start, byte_valid, out_ready;
   logic [7:0]  byte_data;
   logic        byte_ready, busy, out_valid;
   logic [1:0]  out_mod, out_scale;
   logic [2:0]  out_reg, out_rm, out_index, out_base, out_length;
   logic        out_is_register, out_sib_present, out_index_used, out_base_used;
   logic        out_default_ss, out_ea_undefined;
   logic [31:0] out_disp;

   typedef struct {
      logic [1:0]  md;
      logic [2:0]  rg;
      logic [2:0]  rm;
      logic        is_reg;
      logic        sib;
      logic [1:0]  scale;
      logic        idx_used;
      logic [2:0]  idx;
      logic        base_used;
      logic [2:0]  base;
      logic [31:0] disp;
      logic        ss;
      logic        undef;
      logic [2:0]  len;
   } desc_t;

   desc_t exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   decode_modrm_fetch dut (
      .clock(clk), .reset(reset), .flush(flush), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_mod(out_mod), .out_reg(out_reg), .out_rm(out_rm),
      .out_is_register(out_is_register), .out_sib_present(out_sib_present),
      .out_scale(out_scale), .out_index_used(out_index_used), .out_index(out_index),
      .out_base_used(out_base_used), .out_base(out_base), .out_disp(out_disp),
      .out_default_ss(out_default_ss), .out_ea_undefined(out_ea_undefined),
      .out_length(out_length)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_desc(input logic [1:0] md, input logic [2:0] rg, input logic [2:0] rm,
                              input logic is_reg, input logic sib, input logic [1:0] scale,
                              input logic idx_used, input logic [2:0] idx, input logic base_used,
                              input logic [2:0] base, input logic [31:0] disp, input logic ss,
                              input logic undef, input logic [2:0] len);
      desc_t d;
      d.md = md; d.rg = rg; d.rm = rm; d.is_reg = is_reg; d.sib = sib; d.scale = scale;
      d.idx_used = idx_used; d.idx = idx; d.base_used = base_used; d.base = base;
      d.disp = disp; d.ss = ss; d.undef = undef; d.len = len;
      exp_q.push_back(d);
   endtask

   // Monitor: compares every descriptor handshake against the scoreboard
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_desc: got descriptor mod=%0d rm=%0d len=%0d required none",
                     out_mod, out_rm, out_length);
         end else begin
            desc_t e;
            e = exp_q.pop_front();
            check("mod", {30'd0, out_mod}, {30'd0, e.md});
            check("reg", {29'd0, out_reg}, {29'd0, e.rg});
            check("rm", {29'd0, out_rm}, {29'd0, e.rm});
            check("is_register", {31'd0, out_is_register}, {31'd0, e.is_reg});
            check("sib_present", {31'd0, out_sib_present}, {31'd0, e.sib});
            check("scale", {30'd0, out_scale}, {30'd0, e.scale});
            check("index_used", {31'd0, out_index_used}, {31'd0, e.idx_used});
            check("index", {29'd0, out_index}, {29'd0, e.idx});
            check("base_used", {31'd0, out_base_used}, {31'd0, e.base_used});
            check("base", {29'd0, out_base}, {29'd0, e.base});
            check("disp", out_disp, e.disp);
            check("default_ss", {31'd0, out_default_ss}, {31'd0, e.ss});
            check("ea_undefined", {31'd0, out_ea_undefined}, {31'd0, e.undef});
            check("length", {29'd0, out_length}, {29'd0, e.len});
            $display("desc mod=%0d rm=%0d sib=%0d disp=%h len=%0d", out_mod, out_rm,
                     out_sib_present, out_disp, out_length);
         end
      end
   end

   task automatic start_pulse();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      logic got;
      got = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (byte_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL byte_timeout: byte %h never accepted", b);
      end
      @(posedge clk); #1;
      byte_valid = 1'b0;
   endtask

   task automatic wait_idle();
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy && !out_valid && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL idle_timeout: busy=%0d pending=%0d required idle", busy, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; start = 1'b0; byte_valid = 1'b0;
      byte_data = 8'h00; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("rst_length", {29'd0, out_length}, 32'd0);
      check("rst_base_used", {31'd0, out_base_used}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Register form C3 with minimum latency
      expect_desc(2'd3, 3'd0, 3'd3, 1, 0, 2'd0, 0, 3'd0, 1, 3'd3, 32'h0, 0, 0, 3'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; byte_valid = 1'b1; byte_data = 8'hC3;
      @(negedge clk);
      check("c3_byte_ready_t1", {31'd0, byte_ready}, 32'd1);
      @(posedge clk); #1;
      byte_valid = 1'b0;
      @(negedge clk);
      check("c3_out_valid_t2", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
      wait_idle();

      // [EBP+disp8] with disp8 = -8
      expect_desc(2'd1, 3'd0, 3'd5, 0, 0, 2'd0, 0, 3'd0, 1, 3'd5, 32'hFFFFFFF8, 1, 0, 3'd2);
      start_pulse();
      push_byte(8'h45); push_byte(8'hF8);
      wait_idle();

      // SIB with no base, disp32
      expect_desc(2'd0, 3'd0, 3'd4, 0, 1, 2'd2, 1, 3'd1, 0, 3'd5, 32'h12345678, 0, 0, 3'd6);
      start_pulse();
      push_byte(8'h04); push_byte(8'h8D);
      push_byte(8'h78); push_byte(8'h56); push_byte(8'h34); push_byte(8'h12);
      wait_idle();

      // SIB index=100 with scale 11 -> undefined EA
      expect_desc(2'd0, 3'd0, 3'd4, 0, 1, 2'd3, 0, 3'd4, 1, 3'd0, 32'h0, 0, 1, 3'd2);
      start_pulse();
      push_byte(8'h04); push_byte(8'hE0);
      wait_idle();

      // Flush mid-displacement after a stall
      start_pulse();
      push_byte(8'h80); push_byte(8'h78); push_byte(8'h56);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_out_valid", {31'd0, out_valid}, 32'd0);
         check("stall_busy", {31'd0, busy}, 32'd1);
         @(posedge clk); #1;
      end
      flush = 1'b1; byte_valid = 1'b1; byte_data = 8'hAA;
      @(negedge clk);
      check("flush_byte_ready", {31'd0, byte_ready}, 32'd0);
      @(posedge clk); #1;
      flush = 1'b0; byte_valid = 1'b0;
      @(negedge clk);
      check("flush_busy", {31'd0, busy}, 32'd0);
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      expect_desc(2'd0, 3'd0, 3'd0, 0, 0, 2'd0, 0, 3'd0, 1, 3'd0, 32'h0, 0, 0, 3'd1);
      start_pulse();
      push_byte(8'h00);
      wait_idle();

      // Back-pressure: descriptor held, start ignored during DONE
      out_ready = 1'b0;
      expect_desc(2'd1, 3'd0, 3'd5, 0, 0, 2'd0, 0, 3'd0, 1, 3'd5, 32'hFFFFFFF8, 1, 0, 3'd2);
      start_pulse();
      push_byte(8'h45); push_byte(8'hF8);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_disp", out_disp, 32'hFFFFFFF8);
         check("hold_length", {29'd0, out_length}, 32'd2);
         check("hold_byte_ready", {31'd0, byte_ready}, 32'd0);
         @(posedge clk); #1;
      end
      start = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_start_ignored_busy", {31'd0, busy}, 32'd0);
      check("hold_start_ignored_ready", {31'd0, byte_ready}, 32'd0);
      @(posedge clk); #1;

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/decode_modrm_fetch.md
# decode_modrm_fetch

Byte-serial address-field collector sitting between the prefetch queue and the operand/effective-address stage. After the opcode decoder signals that the current instruction carries a ModR/M byte, this block pulls the ModR/M, optional SIB and 0/1/4 displacement bytes from the queue, one per cycle. It emits a single registered address descriptor over a valid/ready handshake. Only 32-bit addressing is supported.

## Interface
- No parameters.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- flush  in  1  discard in-progress parse and pending descriptor
- start  in  1  opcode decoder: next queue byte is a ModR/M byte; sampled only in IDLE
- byte_valid  in  1  queue byte available
- byte_data  in  8  queue byte
- byte_ready  out  1  byte consumed this cycle when byte_valid & byte_ready
- busy  out  1  state != IDLE
- out_valid  out  1  descriptor valid
- out_ready  in  1  consumer accepts descriptor
- out_mod, out_reg, out_rm  out  2/3/3  ModR/M fields
- out_is_register  out  1  mod == 11
- out_sib_present  out  1
- out_scale  out  2, out_index_used  out  1, out_index  out  3  SIB index fields; zero when no SIB
- out_base_used  out  1, out_base  out  3  effective base register
- out_disp  out  32  displacement, disp8 sign-extended; 0 when none
- out_default_ss  out  1  base is ESP or EBP (default segment SS)
- out_ea_undefined  out  1  SIB index = 100 with scale != 00
- out_length  out  3  bytes consumed, 1..6

## Operation
- States: IDLE, MODRM, SIB, DISP, DONE.
- IDLE: start -> MODRM. byte_ready = 0.
- MODRM: on accept, latch the byte.
  - mod=11 -> DONE, length 1.
  - rm=100 -> SIB.
  - mod=00 & rm=101 -> DISP(4), base unused.
  - mod=01 -> DISP(1).
  - mod=10 -> DISP(4).
  - otherwise -> DONE.
- SIB: on accept, latch the byte.
  - Displacement count: mod=01 -> 1; mod=10 -> 4; mod=00 & base=101 -> 4, base unused; else 0.
  - Count 0 -> DONE, else DISP.
- DISP: accepts bytes little-endian into disp[8k+7:8k], decrementing a 3-bit remaining counter. On the last byte -> DONE.
  - When count was 1, disp[31:8] is the sign-extension of byte 0.
- DONE: out_valid = 1. On out_ready -> IDLE.
- Base when no SIB: base = rm, base_used = ~(mod=00 & rm=101). out_default_ss = base_used & base ∈ {100, 101}.
- out_length = 1 + sib_present + displacement byte count.
- byte_ready = state ∈ {MODRM, SIB, DISP}. It is independent of out_ready.
- start outside IDLE is ignored.
- flush has top priority: next state IDLE, out_valid 0 next cycle, any byte offered that cycle not consumed (byte_ready forced 0 during flush).
- Reset: state IDLE; all outputs 0, including out_valid, byte_ready, busy and descriptor fields.

## Timing
- One byte consumed per cycle maximum. byte_valid low stalls the FSM in place with no state loss.
- start in cycle T -> byte_ready high from T+1.
- Last byte accepted in cycle T -> out_valid high in T+1.
- Descriptor outputs are registered and stable while out_valid & ~out_ready.
- Minimum issue interval for a register form: start (T), ModR/M (T+1), out_valid (T+2), out_ready (T+2), IDLE (T+3).
- start asserted in the DONE cycle that handshakes is ignored. Upstream retries in IDLE.
- Reset or flush mid-DISP drops the partial displacement. The next parse starts with disp cleared.

## Structure
- The shared definition header holds the state encoding, the displacement-length constants (0/8/32, same names the SIB decoder uses), and register index constants for ESP/EBP.
- One sub-module: decode_sib, instantiated on the latched SIB byte and mod. It supplies scale, index, base, the displacement class and the undefined flag.
- Displacement assembly and the FSM stay in this module.

## Test plan
- start; bytes C3 -> out_is_register=1, reg=000, rm=011, length=1, disp=0, out_valid 2 cycles after start.
- start; bytes 45 F8 -> mod=01, rm=101, base=101, default_ss=1, disp=FFFFFFF8, length=2.
- start; bytes 04 8D -> SIB present, scale=10, index=001, base=101 with mod=00 gives base_used=0. Then 4 disp bytes 78 56 34 12 -> disp=12345678, length=6.
- start; bytes 04 E0 -> index=100, scale=11, ea_undefined=1, index_used=0, base=000, length=2.
- start; bytes 80 then 2 of 4 disp bytes, byte_valid low for 3 cycles, then flush -> out_valid never rises, FSM returns to IDLE. Next start; 00 decodes with disp=0 and length=1.
- Hold out_ready=0 for 5 cycles after a descriptor -> fields stable, byte_ready=0, and start ignored until the handshake.
